wb_buffer: RTL and testbench

WB_BUFFER -- requirements
Module: wb_buffer

---
 rtl/wb_buffer.sv | 119 +++++++++++
 tb/tb_wb_buffer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// ============================================================================
// wb_buffer : write-back queue in front of the register file, with duplicate
//             PC suppression and youngest-entry forwarding.  Rev 1.0
// ============================================================================
`default_nettype none

module wb_buffer #(
  parameter int DW    = 8,
  parameter int PW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PW:0]              in_addr,
  input  logic [DW-1:0]            in_data,
  input  logic [11:0]              in_pc,
  input  logic                     rf_hold,
  output logic                     rf_wr_en,
  output logic [PW:0]              rf_wr_addr,
  output logic [DW-1:0]            rf_dat,
  output logic [11:0]              rf_prog_ctr,
  input  logic [PW:0]              fwd_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dup_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW:0]     r_mem_addr [DEPTH];
  logic [DW-1:0]   r_mem_data [DEPTH];
  logic [11:0]     r_mem_pc   [DEPTH];

  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [11:0]     r_last_pc;
  logic            r_last_valid;
  logic            r_dup_drop;

  logic            w_hs;
  logic            w_dup;
  logic            w_push;
  logic            w_pop;
  logic            w_not_empty;
  logic            w_fwd_hit;
  logic [DW-1:0]   w_fwd_data;

  assign w_not_empty = (r_count != '0);
  assign in_ready    = (r_count < CW'(DEPTH));
  assign w_hs        = in_valid && in_ready;
  assign w_dup       = w_hs && r_last_valid && (in_pc == r_last_pc);
  assign w_push      = w_hs && !w_dup;
  assign w_pop       = w_not_empty && !rf_hold;

  assign rf_wr_en    = w_pop;
  assign rf_wr_addr  = w_not_empty ? r_mem_addr[r_head] : '0;
  assign rf_dat      = w_not_empty ? r_mem_data[r_head] : '0;
  assign rf_prog_ctr = w_not_empty ? r_mem_pc[r_head]   : 12'hFFF;
  assign count       = r_count;
  assign dup_drop    = r_dup_drop;
  assign fwd_hit     = w_fwd_hit;
  assign fwd_data    = w_fwd_data;

  // Storage is never reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_tail] <= in_addr;
      r_mem_data[r_tail] <= in_data;
      r_mem_pc[r_tail]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_last_pc    <= '0;
      r_last_valid <= 1'b0;
      r_dup_drop   <= 1'b0;
    end else begin
      r_dup_drop <= w_dup;
      if (w_hs) begin
        r_last_pc    <= in_pc;
        r_last_valid <= 1'b1;
      end
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk from oldest to youngest so the last match found wins.
  always_comb begin
    logic [AW-1:0] idx;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    idx        = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + AW'(i);
      if ((CW'(i) < r_count) && (r_mem_addr[idx] == fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_mem_data[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_buffer.sv
// ============================================================================
// tb_wb_buffer : directed self-checking bench for wb_buffer.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_wb_buffer;

  localparam int DW    = 8;
  localparam int PW    = 4;
  localparam int DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW:0]   in_addr;
  logic [DW-1:0] in_data;
  logic [11:0]   in_pc;
  logic          rf_hold;
  logic          rf_wr_en;
  logic [PW:0]   rf_wr_addr;
  logic [DW-1:0] rf_dat;
  logic [11:0]   rf_prog_ctr;
  logic [PW:0]   fwd_addr;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [2:0]    count;
  logic          dup_drop;

  int checks = 0;
  int errors = 0;

  wb_buffer #(.DW(DW), .PW(PW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_pc       (in_pc),
    .rf_hold     (rf_hold),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_dat      (rf_dat),
    .rf_prog_ctr (rf_prog_ctr),
    .fwd_addr    (fwd_addr),
    .fwd_hit     (fwd_hit),
    .fwd_data    (fwd_data),
    .count       (count),
    .dup_drop    (dup_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves time at posedge+1; inputs change here, outputs are read 4 later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    in_pc    = '0;
    rf_hold  = 1'b0;
    fwd_addr = '0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    fwd_addr = '0;
    #4;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", rf_wr_en); end
    checks++; if (rf_wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", rf_wr_addr); end
    checks++; if (rf_dat !== 8'h00) begin errors++; $display("FAIL reset_dat got %h want 00", rf_dat); end
    checks++; if (rf_prog_ctr !== 12'hFFF) begin errors++; $display("FAIL reset_pc got %h want FFF", rf_prog_ctr); end
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit got %b want 0", fwd_hit); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL reset_dup_drop got %b want 0", dup_drop); end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    in_valid = 1'b1; in_addr = 5'd3; in_data = 8'h5A; in_pc = 12'h010;
    #4;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b want 0", rf_wr_en); end
    step();
    in_valid = 1'b0;
    #4;
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL single_wr_en got %b want 1", rf_wr_en); end
    checks++; if (rf_wr_addr !== 5'd3) begin errors++; $display("FAIL single_addr got %0d want 3", rf_wr_addr); end
    checks++; if (rf_dat !== 8'h5A) begin errors++; $display("FAIL single_dat got %h want 5A", rf_dat); end
    checks++; if (rf_prog_ctr !== 12'h010) begin errors++; $display("FAIL single_pc got %h want 010", rf_prog_ctr); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d want 1", count); end
    step();
    #4;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count0 got %0d want 0", count); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", rf_wr_en); end
  endtask

  task automatic test_duplicate();
    do_reset();
    in_valid = 1'b1; in_addr = 5'd2; in_data = 8'h01; in_pc = 12'h020;
    step();
    in_data = 8'h02;
    #4;
    checks++; if (rf_dat !== 8'h01) begin errors++; $display("FAIL dup_first_dat got %h want 01", rf_dat); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL dup_count1 got %0d want 1", count); end
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL dup_early_pulse got %b want 0", dup_drop); end
    step();
    in_valid = 1'b0;
    #4;
    checks++; if (dup_drop !== 1'b1) begin errors++; $display("FAIL dup_pulse got %b want 1", dup_drop); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL dup_not_stored got %0d want 0", count); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL dup_no_write got %b want 0", rf_wr_en); end
    step();
    #4;
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL dup_one_cycle got %b want 0", dup_drop); end
  endtask

  task automatic test_fill_hold();
    do_reset();
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr  = 5'(i + 1);
      in_data  = 8'hA0 + 8'(i);
      in_pc    = 12'h100 + 12'(i);
      step();
    end
    // Offer a fresh pc while full; it must not be taken nor recorded.
    in_pc = 12'h1F0; in_data = 8'hEE;
    #4;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", in_ready); end
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL fill_hold_wr got %b want 0", rf_wr_en); end
    step();
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    #4;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL drain_wr_en[%0d] got %b want 1", i, rf_wr_en); end
      checks++; if (rf_dat !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL drain_dat[%0d] got %h want %h", i, rf_dat, 8'hA0 + 8'(i)); end
      checks++; if (rf_prog_ctr !== 12'h100 + 12'(i)) begin errors++; $display("FAIL drain_pc[%0d] got %h want %h", i, rf_prog_ctr, 12'h100 + 12'(i)); end
      checks++; if (rf_wr_addr !== 5'(i + 1)) begin errors++; $display("FAIL drain_addr[%0d] got %0d want %0d", i, rf_wr_addr, i + 1); end
      step();
      #4;
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d want 0", count); end
    step();
    in_valid = 1'b1; in_addr = 5'd9; in_data = 8'hEE; in_pc = 12'h1F0;
    step();
    in_valid = 1'b0;
    #4;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL full_offer_not_recorded got %0d want 1", count); end
    checks++; if (dup_drop !== 1'b0) begin errors++; $display("FAIL full_offer_dup got %b want 0", dup_drop); end
    step();
  endtask

  task automatic test_forward();
    do_reset();
    rf_hold = 1'b1;
    in_valid = 1'b1; in_addr = 5'd5; in_data = 8'h11; in_pc = 12'h001;
    step();
    in_data = 8'h22; in_pc = 12'h002;
    step();
    in_valid = 1'b0;
    fwd_addr = 5'd5;
    #4;
    checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit got %b want 1", fwd_hit); end
    checks++; if (fwd_data !== 8'h22) begin errors++; $display("FAIL fwd_youngest got %h want 22", fwd_data); end
    fwd_addr = 5'd6;
    #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss got %b want 0", fwd_hit); end
    checks++; if (fwd_data !== 8'h00) begin errors++; $display("FAIL fwd_miss_data got %h want 00", fwd_data); end
    fwd_addr = 5'd5;
    rf_hold  = 1'b0;
    step();
    #4;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL fwd_pop_count got %0d want 1", count); end
    checks++; if (rf_wr_en !== 1'b1 || rf_dat !== 8'h22) begin errors++; $display("FAIL fwd_pop_head got en=%b dat=%h want en=1 dat=22", rf_wr_en, rf_dat); end
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 8'h22) begin errors++; $display("FAIL fwd_during_pop got hit=%b data=%h want hit=1 data=22", fwd_hit, fwd_data); end
    step();
    #4;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 8'h00) begin errors++; $display("FAIL fwd_after_drain got hit=%b data=%h want hit=0 data=00", fwd_hit, fwd_data); end
    fwd_addr = '0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_addr  = 5'(i);
      in_data  = 8'h30 + 8'(i);
      in_pc    = 12'h200 + 12'(i);
      #4;
      if (i > 0) begin
        checks++; if (rf_wr_en !== 1'b1 || rf_dat !== 8'h30 + 8'(i - 1)) begin errors++; $display("FAIL wrap_order[%0d] got en=%b dat=%h want en=1 dat=%h", i, rf_wr_en, rf_dat, 8'h30 + 8'(i - 1)); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count[%0d] got %0d want 1", i, count); end
      end
      step();
    end
    in_valid = 1'b0;
    #4;
    checks++; if (rf_dat !== 8'h39 || rf_prog_ctr !== 12'h209) begin errors++; $display("FAIL wrap_last got dat=%h pc=%h want dat=39 pc=209", rf_dat, rf_prog_ctr); end
    step();
    #4;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    rf_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_addr  = 5'(i + 10);
      in_data  = 8'h60 + 8'(i);
      in_pc    = (i == 2) ? 12'h020 : 12'h300 + 12'(i);
      step();
    end
    in_valid = 1'b0;
    rf_hold  = 1'b0;
    #4;
    checks++; if (count !== 3'd3 || rf_wr_en !== 1'b1) begin errors++; $display("FAIL mid_pre got count=%0d en=%b want count=3 en=1", count, rf_wr_en); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL mid_wr_en got %b want 0", rf_wr_en); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
    checks++; if (in_ready !== 1'b1 || rf_prog_ctr !== 12'hFFF) begin errors++; $display("FAIL mid_outputs got ready=%b pc=%h want ready=1 pc=FFF", in_ready, rf_prog_ctr); end
    step();
    reset_n = 1'b1;
    step();
    in_valid = 1'b1; in_addr = 5'd7; in_data = 8'h77; in_pc = 12'h020;
    step();
    in_valid = 1'b0;
    #4;
    checks++; if (count !== 3'd1 || dup_drop !== 1'b0) begin errors++; $display("FAIL mid_first_push got count=%0d dup=%b want count=1 dup=0", count, dup_drop); end
    checks++; if (rf_wr_en !== 1'b1 || rf_dat !== 8'h77) begin errors++; $display("FAIL mid_first_write got en=%b dat=%h want en=1 dat=77", rf_wr_en, rf_dat); end
    step();
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    in_pc    = '0;
    rf_hold  = 1'b0;
    fwd_addr = '0;
    step();
    test_reset();
    test_single_write();
    test_duplicate();
    test_fill_hold();
    test_forward();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
